// File: rtl/code_sequencer.sv
// Auto/manual stepping 5-bit code sequencer for a 7-segment decoder stage.
// Optional button debounce is enabled with `define CODE_SEQUENCER_DEBOUNCE_EN.
module code_sequencer #(
  parameter int unsigned CLK_DIV         = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_CODE        = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       dir,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] code,
  output logic       running
);

  localparam int unsigned CW = 5;
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] MAX_C      = CW'(MAX_CODE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  // Reset release: en stalls the first edge, sync_vld marks the sync chain as filled
  logic [2:0] rst_q;
  logic       en;
  logic       sync_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[1:0], 1'b1};
  end

  assign en       = rst_q[0];
  assign sync_vld = rst_q[2];

  // Two-flop synchronizers, bit order {dir, btn_step, btn_run}
  logic [2:0] meta;
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else if (en) begin
      meta <= {dir, btn_step, btn_run};
      sync <= meta;
    end
  end

  // Accepted button levels, bit order {btn_step, btn_run}
  logic [1:0] lvl;

`ifdef CODE_SEQUENCER_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          lvl[i]    <= sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end
`else
  assign lvl = sync[1:0];
`endif

  // Rising-edge pulses; a button held through reset must be seen released first
  logic [1:0] lvl_q;
  logic [1:0] armed;
  logic [1:0] pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      armed <= '0;
    end else if (en) begin
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync_vld && !sync[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign pulse = lvl & ~lvl_q & armed & {2{en}};

  state_t          state, state_next;
  logic [PW-1:0]   presc, presc_next;
  logic [CW-1:0]   code_next;
  logic            tick;
  logic            step_ev;

  always_comb begin
    state_next = state;
    presc_next = '0;
    code_next  = code;
    tick       = 1'b0;
    step_ev    = 1'b0;

    if (state == RUN) begin
      tick       = (presc == PRESC_LAST);
      presc_next = tick ? '0 : presc + PW'(1);
      step_ev    = tick;
    end else begin
      step_ev    = pulse[1];
    end

    // Step is judged against the current state; the toggle lands afterwards
    if (pulse[0]) begin
      state_next = (state == RUN) ? HOLD : RUN;
      presc_next = '0;
    end

    if (load) begin
      code_next  = (load_val > MAX_C) ? MAX_C : load_val;
      presc_next = '0;
    end else if (step_ev) begin
      if (!sync[2]) code_next = (code >= MAX_C) ? '0 : code + CW'(1);
      else          code_next = (code == '0 || code > MAX_C) ? MAX_C : code - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      presc   <= '0;
      code    <= '0;
      running <= 1'b0;
    end else if (en) begin
      state   <= state_next;
      presc   <= presc_next;
      code    <= code_next;
      running <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_code_sequencer.sv
// Directed self-checking bench for code_sequencer (CLK_DIV=4, DEBOUNCE_CYCLES=3, MAX_CODE=9).
module tb_code_sequencer;

`ifdef CODE_SEQUENCER_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_run;
  logic       btn_step;
  logic       dir;
  logic       load;
  logic [4:0] load_val;
  logic [4:0] code;
  logic       running;

  int errors = 0;
  int checks = 0;

  code_sequencer #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .MAX_CODE(9)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step), .dir(dir),
    .load(load), .load_val(load_val), .code(code), .running(running)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] v);
    load = 1'b1; load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b1; load_val = 5'd5;
    btn_run = 1'b0; btn_step = 1'b0; dir = 1'b0;
    #12;
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", code); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", running); end
    @(negedge clk) rst_n = 1'b1;
    cyc(1);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL release_first_edge: got %0d want 0", code); end
    cyc(1);
    checks++; if (code !== 5'd5) begin errors++; $display("FAIL release_second_edge: got %0d want 5", code); end
    load = 1'b0;
    cyc(6);
  endtask

  task automatic test_step_single;
    do_load(5'd0);
    btn_step = 1'b1;
    cyc(LAT - 1);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL step_early: got %0d want 0", code); end
    cyc(1);
    checks++; if (code !== 5'd1) begin errors++; $display("FAIL step_edge: got %0d want 1", code); end
    cyc(20 - LAT);
    checks++; if (code !== 5'd1) begin errors++; $display("FAIL step_held_once: got %0d want 1", code); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running: got %0b want 0", running); end
    btn_step = 1'b0;
    cyc(8);
  endtask

  task automatic test_wrap;
    do_load(5'd9);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL load9: got %0d want 9", code); end
    btn_step = 1'b1; cyc(LAT);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL wrap_up: got %0d want 0", code); end
    btn_step = 1'b0; cyc(8);
    dir = 1'b1; cyc(4);
    do_load(5'd0);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL load0: got %0d want 0", code); end
    btn_step = 1'b1; cyc(LAT);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL wrap_down: got %0d want 9", code); end
    btn_step = 1'b0; cyc(8);
    btn_step = 1'b1; cyc(LAT);
    checks++; if (code !== 5'd8) begin errors++; $display("FAIL count_down: got %0d want 8", code); end
    btn_step = 1'b0; cyc(8);
    do_load(5'd25);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL load_clamp: got %0d want 9", code); end
    dir = 1'b0; cyc(4);
  endtask

  task automatic test_run;
    logic [4:0] exp_stop;
    do_load(5'd3);
    btn_run = 1'b1; cyc(LAT);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_start: got %0b want 1", running); end
    btn_run = 1'b0;
    cyc(3);
    checks++; if (code !== 5'd3) begin errors++; $display("FAIL run_no_early_tick: got %0d want 3", code); end
    cyc(1);
    checks++; if (code !== 5'd4) begin errors++; $display("FAIL run_tick1: got %0d want 4", code); end
    cyc(4);
    checks++; if (code !== 5'd5) begin errors++; $display("FAIL run_tick2: got %0d want 5", code); end
    cyc(4);
    checks++; if (code !== 5'd6) begin errors++; $display("FAIL run_tick3: got %0d want 6", code); end
    exp_stop = 5'(6 + LAT / 4);
    btn_run = 1'b1; cyc(LAT);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_stop: got %0b want 0", running); end
    checks++; if (code !== exp_stop) begin errors++; $display("FAIL run_stop_code: got %0d want %0d", code, exp_stop); end
    btn_run = 1'b0; cyc(12);
    checks++; if (code !== exp_stop) begin errors++; $display("FAIL run_frozen: got %0d want %0d", code, exp_stop); end
  endtask

  task automatic test_load_run;
    do_load(5'd2);
    btn_run = 1'b1; cyc(LAT); btn_run = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL loadrun_start: got %0b want 1", running); end
    load = 1'b1; load_val = 5'd12;
    cyc(10);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL load_hold_run: got %0d want 9", code); end
    load = 1'b0;
    cyc(3);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL load_presc_clear: got %0d want 9", code); end
    cyc(1);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL load_then_tick: got %0d want 0", code); end
    btn_run = 1'b1; cyc(LAT); btn_run = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL loadrun_stop: got %0b want 0", running); end
    cyc(8);
  endtask

  task automatic test_reset_mid_run;
    do_load(5'd7);
    btn_run = 1'b1; cyc(LAT); btn_run = 1'b0;
    btn_step = 1'b1;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrun_start: got %0b want 1", running); end
    cyc(2);
    checks++; if (code !== 5'd7) begin errors++; $display("FAIL midrun_pre_reset: got %0d want 7", code); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL midrun_reset_code: got %0d want 0", code); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_reset_running: got %0b want 0", running); end
    #10 rst_n = 1'b1;
    cyc(15);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL held_no_step: got %0d want 0", code); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_running: got %0b want 0", running); end
    btn_step = 1'b0; cyc(8);
    btn_step = 1'b1; cyc(LAT);
    checks++; if (code !== 5'd1) begin errors++; $display("FAIL repress_step: got %0d want 1", code); end
    btn_step = 1'b0; cyc(8);
  endtask

  task automatic test_glitch;
    logic [4:0] exp_g;
`ifdef CODE_SEQUENCER_DEBOUNCE_EN
    exp_g = 5'd4;
`else
    exp_g = 5'd5;
`endif
    do_load(5'd4);
    btn_step = 1'b1; cyc(2); btn_step = 1'b0;
    cyc(10);
    checks++; if (code !== exp_g) begin errors++; $display("FAIL short_press: got %0d want %0d", code, exp_g); end
  endtask

  initial begin
    test_reset();
    test_step_single();
    test_wrap();
    test_run();
    test_load_run();
    test_reset_mid_run();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
